// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Optional checksum stage is enabled with IMEM_LOADER_CSUM_EN.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR0  = 3'd0,
        HDR1  = 3'd1,
        DATA  = 3'd2,
        CSUM  = 3'd3,
        FIN   = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = 16;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles accepted bytes LSB-first into 32-bit words and emits a one-cycle
// word_valid strobe with the completed word held until the next completion.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        lane_last,
    output logic        word_valid,
    output logic [31:0] word_data
);

    localparam int LANE_W  = $clog2(BYTES_PER_WORD);
    localparam int SHIFT_W = 8 * (BYTES_PER_WORD - 1);

    logic [LANE_W-1:0]  r_lane;
    logic [SHIFT_W-1:0] r_shift;
    logic               r_word_valid;
    logic [31:0]        r_word;

    assign lane_last  = (r_lane == LANE_W'(BYTES_PER_WORD - 1));
    assign word_valid = r_word_valid;
    assign word_data  = r_word;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_lane       <= '0;
            r_shift      <= '0;
            r_word_valid <= 1'b0;
            r_word       <= '0;
        end else begin
            r_word_valid <= 1'b0;
            if (byte_valid) begin
                if (lane_last) begin
                    // Earlier bytes have shifted down to the low lanes already.
                    r_word       <= {byte_data, r_shift};
                    r_word_valid <= 1'b1;
                    r_lane       <= '0;
                end else begin
                    r_shift <= {byte_data, r_shift[SHIFT_W-1:8]};
                    r_lane  <= r_lane + LANE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a count-prefixed byte frame, writes words to instruction
// memory from address 0 and releases core reset. Checksum stage: IMEM_LOADER_CSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_core_rst;
    logic              r_done;
    logic              r_error;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_cnt_lo;
    logic [CNT_W-1:0]  r_words_left;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]        r_csum;
`endif

    logic              w_accept;
    logic              w_pack_valid;
    logic              w_lane_last;
    logic              w_word_valid;
    logic [31:0]       w_word;
    logic              w_clr;
    logic [CNT_W-1:0]  w_count;

    assign w_accept     = in_valid & r_in_ready;
    assign w_pack_valid = w_accept && (r_state == DATA);
    assign w_clr        = reload && (r_state == DONE || r_state == ERROR);
    assign w_count      = {in_data, r_cnt_lo};

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (w_clr),
        .byte_valid (w_pack_valid),
        .byte_data  (in_data),
        .lane_last  (w_lane_last),
        .word_valid (w_word_valid),
        .word_data  (w_word)
    );

    assign in_ready  = r_in_ready;
    assign mem_we    = w_word_valid;
    assign mem_addr  = r_addr;
    assign mem_wdata = w_word;
    assign core_rst  = r_core_rst;
    assign done      = r_done;
    assign error     = r_error;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= HDR0;
            r_in_ready   <= 1'b0;
            r_core_rst   <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_addr       <= '0;
            r_cnt_lo     <= '0;
            r_words_left <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            if (w_word_valid) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
`ifdef IMEM_LOADER_CSUM_EN
            if (w_accept && (r_state == HDR0 || r_state == HDR1 || r_state == DATA)) begin
                r_csum <= r_csum ^ in_data;
            end
`endif
            case (r_state)
                HDR0: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_cnt_lo <= in_data;
                        r_state  <= HDR1;
                    end
                end
                HDR1: begin
                    if (w_accept) begin
                        if (32'(w_count) > MAX_WORDS) begin
                            r_state    <= ERROR;
                            r_in_ready <= 1'b0;
                            r_error    <= 1'b1;
                        end else if (w_count == '0) begin
`ifdef IMEM_LOADER_CSUM_EN
                            r_state    <= CSUM;
`else
                            r_state    <= FIN;
                            r_in_ready <= 1'b0;
`endif
                        end else begin
                            r_state      <= DATA;
                            r_words_left <= w_count;
                        end
                    end
                end
                DATA: begin
                    if (w_accept && w_lane_last) begin
                        r_words_left <= r_words_left - CNT_W'(1);
                        if (r_words_left == CNT_W'(1)) begin
`ifdef IMEM_LOADER_CSUM_EN
                            r_state    <= CSUM;
`else
                            r_state    <= FIN;
                            r_in_ready <= 1'b0;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CSUM_EN
                CSUM: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (in_data == r_csum) begin
                            r_state <= FIN;
                        end else begin
                            r_state <= ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
`endif
                // FIN separates the last memory write from core release.
                FIN: begin
                    r_state    <= DONE;
                    r_done     <= 1'b1;
                    r_core_rst <= 1'b0;
                end
                DONE, ERROR: begin
                    if (reload) begin
                        r_state      <= HDR0;
                        r_in_ready   <= 1'b1;
                        r_core_rst   <= 1'b1;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                        r_addr       <= '0;
                        r_cnt_lo     <= '0;
                        r_words_left <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                        r_csum       <= '0;
`endif
                    end
                end
                default: begin
                    r_state    <= HDR0;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader; expected writes come from the word list
// and frame rules, checksum handling follows IMEM_LOADER_CSUM_EN.
module tb_imem_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              reload = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_rst;
    logic              done;
    logic              error;

    int checks = 0;
    int errors = 0;

    logic [31:0] tx_words[$];
    int unsigned wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          we_long = 0;
    logic        we_prev = 1'b0;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .reload    (reload),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst  (core_rst),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Write monitor: record every strobe and flag strobes longer than one cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(mem_wdata);
            if (we_prev) we_long++;
        end
        we_prev = (mem_we === 1'b1);
    end

    task automatic do_reset();
        in_valid = 1'b0;
        reload   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
        we_long = 0;
    endtask

    // Returns on the negedge following the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int t;
        for (int g = 0; g < 8 && int'($urandom_range(99)) < gap_pct; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input int gap_pct);
        logic [7:0] x;
        logic [7:0] b;
        logic [15:0] cnt;
        cnt = 16'(n);
        x = cnt[7:0] ^ cnt[15:8];
        send_byte(cnt[7:0], gap_pct);
        send_byte(cnt[15:8], gap_pct);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = tx_words[i][8*k +: 8];
                x ^= b;
                send_byte(b, gap_pct);
            end
        end
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(x, gap_pct);
`else
        x = 8'h00;
`endif
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!(done === 1'b1 || error === 1'b1) && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done !== 1'b1 || core_rst !== 1'b0) begin
            errors++;
            $display("FAIL wait_done done=%b core_rst=%b error=%b required done=1 core_rst=0", done, core_rst, error);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        checks++;
        if ({core_rst, in_ready, mem_we, done, error} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags {core_rst,in_ready,mem_we,done,error}=%b required 10000",
                     {core_rst, in_ready, mem_we, done, error});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem addr=%0h wdata=%h required 0/0", mem_addr, mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] x;
        do_reset();
        tx_words.delete();
        tx_words.push_back(32'h00500013);
        tx_words.push_back(32'h00100093);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        x = 8'h02;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) begin
                x ^= tx_words[i][8*k +: 8];
                send_byte(tx_words[i][8*k +: 8], 0);
            end
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(i) || mem_wdata !== tx_words[i]) begin
                errors++;
                $display("FAIL basic_write%0d we=%b addr=%0d data=%h required 1/%0d/%h",
                         i, mem_we, mem_addr, mem_wdata, i, tx_words[i]);
            end
        end
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(x, 0);
`endif
        checks++;
        if (done !== 1'b0 || core_rst !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_fin done=%b core_rst=%b in_ready=%b required 0/1/0", done, core_rst, in_ready);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || core_rst !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL basic_done done=%b core_rst=%b error=%b required 1/0/0", done, core_rst, error);
        end
        checks++;
        if (wr_addr_q.size() != 2 || we_long != 0) begin
            errors++;
            $display("FAIL basic_count writes=%0d long=%0d required 2/0", wr_addr_q.size(), we_long);
        end
    endtask

    // Runs from DONE: reload collides with a valid byte, which must be dropped.
    task automatic test_reload();
        int n;
        in_valid = 1'b1;
        in_data  = 8'h55;
        reload   = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reload_ready_done in_ready=%b required 0", in_ready);
        end
        @(negedge clk);
        reload   = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({done, core_rst, error, in_ready} !== 4'b0101 || mem_addr !== '0) begin
            errors++;
            $display("FAIL reload_state {done,core_rst,error,in_ready}=%b addr=%0d required 0101/0",
                     {done, core_rst, error, in_ready}, mem_addr);
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        n = 3;
        tx_words.delete();
        for (int i = 0; i < n; i++) tx_words.push_back($urandom);
        send_frame(n, 0);
        wait_done();
        checks++;
        if (wr_addr_q.size() != n) begin
            errors++;
            $display("FAIL reload_count writes=%0d required %0d", wr_addr_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (wr_addr_q[i] != i || wr_data_q[i] !== tx_words[i]) begin
                    errors++;
                    $display("FAIL reload_write%0d addr=%0d data=%h required %0d/%h",
                             i, wr_addr_q[i], wr_data_q[i], i, tx_words[i]);
                end
            end
        end
    endtask

`ifdef IMEM_LOADER_CSUM_EN
    task automatic test_bad_csum();
        do_reset();
        tx_words.delete();
        tx_words.push_back(32'h00500013);
        tx_words.push_back(32'h00100093);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) send_byte(tx_words[i][8*k +: 8], 0);
        send_byte(8'h00, 0);
        checks++;
        if ({error, core_rst, in_ready, done} !== 4'b1100) begin
            errors++;
            $display("FAIL badcsum_state {error,core_rst,in_ready,done}=%b required 1100",
                     {error, core_rst, in_ready, done});
        end
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || error !== 1'b1) begin
            errors++;
            $display("FAIL badcsum_hold in_ready=%b error=%b required 0/1", in_ready, error);
        end
        in_valid = 1'b0;
        reload   = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        checks++;
        if (error !== 1'b0 || in_ready !== 1'b1 || core_rst !== 1'b1) begin
            errors++;
            $display("FAIL badcsum_reload error=%b in_ready=%b core_rst=%b required 0/1/1", error, in_ready, core_rst);
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        send_frame(2, 0);
        wait_done();
        checks++;
        if (wr_addr_q.size() != 2 || wr_data_q[1] !== 32'h00100093) begin
            errors++;
            $display("FAIL badcsum_retry writes=%0d required 2 with word1 00100093", wr_addr_q.size());
        end
    endtask
`endif

    task automatic test_overflow();
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        checks++;
        if ({error, core_rst, in_ready, done} !== 4'b1100) begin
            errors++;
            $display("FAIL overflow_state {error,core_rst,in_ready,done}=%b required 1100",
                     {error, core_rst, in_ready, done});
        end
        in_valid = 1'b1;
        in_data  = 8'h13;
        repeat (8) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (wr_addr_q.size() != 0 || error !== 1'b1) begin
            errors++;
            $display("FAIL overflow_writes writes=%0d error=%b required 0/1", wr_addr_q.size(), error);
        end
    endtask

    task automatic test_full_capacity();
        int n;
        int bad;
        n = 1 << ADDR_W;
        do_reset();
        tx_words.delete();
        for (int i = 0; i < n; i++) tx_words.push_back($urandom);
        send_frame(n, 0);
        wait_done();
        bad = 0;
        for (int i = 0; i < n && i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] != i || wr_data_q[i] !== tx_words[i]) bad++;
        checks++;
        if (wr_addr_q.size() != n || bad != 0) begin
            errors++;
            $display("FAIL full_capacity writes=%0d bad=%0d required %0d/0", wr_addr_q.size(), bad, n);
        end
    endtask

    task automatic test_zero();
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CSUM_EN
        checks++;
        if (in_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL zero_csum_wait in_ready=%b done=%b required 1/0", in_ready, done);
        end
        send_byte(8'h00, 0);
`endif
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_fin done=%b in_ready=%b required 0/0", done, in_ready);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || core_rst !== 1'b0 || wr_addr_q.size() != 0) begin
            errors++;
            $display("FAIL zero_done done=%b core_rst=%b writes=%0d required 1/0/0", done, core_rst, wr_addr_q.size());
        end
    endtask

    task automatic test_gaps();
        int n;
        n = 4;
        do_reset();
        tx_words.delete();
        for (int i = 0; i < n; i++) tx_words.push_back($urandom);
        send_frame(n, 50);
        wait_done();
        checks++;
        if (wr_addr_q.size() != n || we_long != 0) begin
            errors++;
            $display("FAIL gaps_count writes=%0d long=%0d required %0d/0", wr_addr_q.size(), we_long, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (wr_addr_q[i] != i || wr_data_q[i] !== tx_words[i]) begin
                    errors++;
                    $display("FAIL gaps_write%0d addr=%0d data=%h required %0d/%h",
                             i, wr_addr_q[i], wr_data_q[i], i, tx_words[i]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        tx_words.delete();
        tx_words.push_back($urandom);
        tx_words.push_back($urandom);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int j = 0; j < 6; j++) send_byte(tx_words[j / 4][8*(j % 4) +: 8], 0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
        checks++;
        if (in_ready !== 1'b0 || mem_addr !== '0 || core_rst !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state in_ready=%b addr=%0d core_rst=%b required 0/0/1", in_ready, mem_addr, core_rst);
        end
        tx_words.delete();
        tx_words.push_back($urandom);
        send_frame(1, 0);
        wait_done();
        checks++;
        if (wr_addr_q.size() != 1 || wr_addr_q[0] != 0 || wr_data_q[0] !== tx_words[0]) begin
            errors++;
            $display("FAIL midreset_write writes=%0d data=%h required 1 write at 0 of %h",
                     wr_addr_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0, tx_words[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reload();
`ifdef IMEM_LOADER_CSUM_EN
        test_bad_csum();
`endif
        test_overflow();
        test_zero();
        test_gaps();
        test_mid_reset();
        test_full_capacity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
